// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_serializer
//  Description : Parallel-to-serial stage. Accepts WIDTH-bit words over a
//                valid/ready handshake and drives one registered bit per
//                clock. A one-word holding buffer lets words stream gap-free.
//  Revision    : 1.0  initial release
// ============================================================================
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int c_CW = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0] c_CNT_PRE  = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(WIDTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [WIDTH-1:0]   r_shift;
    logic [c_CW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_hold;
    logic               r_hold_full;
    logic               r_bit_out;
    logic               r_bit_valid;
    logic               r_word_done;

    logic               w_xfer;
    logic               w_last;
    logic               w_load;
    logic [WIDTH-1:0]   w_ld_word;
    logic               w_step;
    logic               w_hold_wr;
    logic               w_hold_rd;

    // Bit-order selection: "first" is the bit driven now, "rest" is what
    // remains queued in the shifter with the next bit in the lead position.
    logic               w_ld_first;
    logic [WIDTH-1:0]   w_ld_rest;
    logic               w_sh_first;
    logic [WIDTH-1:0]   w_sh_rest;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_ld_first = w_ld_word[WIDTH-1];
            assign w_ld_rest  = {w_ld_word[WIDTH-2:0], 1'b0};
            assign w_sh_first = r_shift[WIDTH-1];
            assign w_sh_rest  = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_ld_first = w_ld_word[0];
            assign w_ld_rest  = {1'b0, w_ld_word[WIDTH-1:1]};
            assign w_sh_first = r_shift[0];
            assign w_sh_rest  = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    // Ready depends only on reset and buffer occupancy, never on din_valid.
    assign din_ready = !rst && !r_hold_full;
    assign w_xfer    = din_valid && din_ready;
    // The last bit of the current word is on bit_out this cycle.
    assign w_last    = (r_state == S_SHIFT) && (r_cnt == c_CNT_FULL);

    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign word_done = r_word_done;
    assign busy      = (r_state == S_SHIFT) || r_hold_full;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and datapath control: load, shift, buffer write/read.
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_ld_word  = din;
        w_step     = 1'b0;
        w_hold_wr  = 1'b0;
        w_hold_rd  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_load     = 1'b1;
                    w_state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    // Held word takes priority; ready is low when it exists.
                    if (r_hold_full) begin
                        w_load    = 1'b1;
                        w_ld_word = r_hold;
                        w_hold_rd = 1'b1;
                    end else if (w_xfer) begin
                        w_load    = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_step    = 1'b1;
                    w_hold_wr = w_xfer;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Shifter, bit counter and registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_word_done <= 1'b0;
        end else if (w_load) begin
            r_shift     <= w_ld_rest;
            r_cnt       <= c_CNT_ONE;
            r_bit_out   <= w_ld_first;
            r_bit_valid <= 1'b1;
            r_word_done <= 1'b0;
        end else if (w_step) begin
            r_shift     <= w_sh_rest;
            r_cnt       <= r_cnt + c_CNT_ONE;
            r_bit_out   <= w_sh_first;
            r_bit_valid <= 1'b1;
            r_word_done <= (r_cnt == c_CNT_PRE);
        end else begin
            r_cnt       <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_word_done <= 1'b0;
        end
    end

    // One-word holding buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_hold_wr) begin
            r_hold      <= din;
            r_hold_full <= 1'b1;
        end else if (w_hold_rd) begin
            r_hold_full <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_serializer
//  Description : Self-checking bench for bit_serializer. An MSB-first and an
//                LSB-first instance share the same stimulus; a word-queue
//                model predicts every output on every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;

    logic m_rdy, m_bo, m_bv, m_wd, m_bz;
    logic l_rdy, l_bo, l_bv, l_wd, l_bz;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(m_rdy), .bit_out(m_bo), .bit_valid(m_bv),
        .word_done(m_wd), .busy(m_bz)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(l_rdy), .bit_out(l_bo), .bit_valid(l_bv),
        .word_done(l_wd), .busy(l_bz)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: a queue of accepted-but-unstarted words plus the word
    // currently on the wire and how many of its bits have been shown.
    logic [7:0] q[$];
    logic [7:0] cur;
    int         pos = 0;
    bit         active = 0;

    // Directed-test observation helpers.
    logic [31:0] cap_m, cap_l;
    int          wd_cnt;
    int          idle_cnt;
    bit          rdy_dropped;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        bit xfer;
        if (rst) begin
            q.delete();
            active = 0;
            pos    = 0;
        end else begin
            xfer = din_valid && (q.size() == 0);
            if (active && pos < 8) begin
                pos++;
                if (xfer) q.push_back(din);
            end else if (q.size() != 0) begin
                cur = q.pop_front(); pos = 1; active = 1;
            end else if (xfer) begin
                cur = din; pos = 1; active = 1;
            end else begin
                active = 0; pos = 0;
            end
        end
    endtask

    task automatic chk_inst(input string tag, input bit msb,
                            input logic rdy, input logic bo, input logic bv,
                            input logic wd, input logic bz);
        logic e_bo;
        e_bo = 1'b0;
        if (active) e_bo = msb ? cur[8-pos] : cur[pos-1];
        chk({tag, ".bit_valid"}, 32'(bv), 32'(active));
        chk({tag, ".bit_out"},   32'(bo), 32'(e_bo));
        chk({tag, ".word_done"}, 32'(wd), 32'(active && pos == 8));
        chk({tag, ".busy"},      32'(bz), 32'(active || q.size() != 0));
        chk({tag, ".din_ready"}, 32'(rdy), 32'(!rst && q.size() == 0));
    endtask

    // One clock: model follows the edge, then all outputs are compared.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk_inst("msb", 1'b1, m_rdy, m_bo, m_bv, m_wd, m_bz);
        chk_inst("lsb", 1'b0, l_rdy, l_bo, l_bv, l_wd, l_bz);
        if (m_bv) cap_m = {cap_m[30:0], m_bo};
        if (l_bv) cap_l = {cap_l[30:0], l_bo};
        if (m_wd) wd_cnt++;
        if (!m_bv) idle_cnt++;
        if (!m_rdy) rdy_dropped = 1;
    endtask

    task automatic clr();
        cap_m = '0; cap_l = '0; wd_cnt = 0; idle_cnt = 0; rdy_dropped = 0;
    endtask

    task automatic send(input logic [7:0] w);
        din = w; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = '0; din_valid = 1'b0;
        clr();
        step(); step();
        chk("reset.bit_valid", 32'(m_bv), 32'd0);
        chk("reset.din_ready", 32'(m_rdy), 32'd0);
        chk("reset.busy",      32'(m_bz), 32'd0);
        rst = 1'b0;
        step();

        // Single word, both bit orders.
        clr(); send(8'hD0); repeat (7) step();
        chk("single.msb_stream", cap_m, 32'h0000_00D0);
        chk("single.lsb_stream", cap_l, 32'h0000_000B);
        chk("single.word_done",  32'(wd_cnt), 32'd1);
        step();
        chk("single.busy_after", 32'(m_bz), 32'd0);

        // LSB-first word 0x0B presents 1,1,0,1,0,0,0,0.
        clr(); send(8'h0B); repeat (7) step();
        chk("lsb.stream", cap_l, 32'h0000_00D0);
        step();

        // Back-to-back with valid held high.
        clr(); din = 8'hA5; din_valid = 1'b1; step();
        din = 8'h3C; step();
        din_valid = 1'b0;
        chk("b2b.ready_low", 32'(m_rdy), 32'd0);
        repeat (14) step();
        chk("b2b.stream",    cap_m, 32'h0000_A53C);
        chk("b2b.word_done", 32'(wd_cnt), 32'd2);
        chk("b2b.gapless",   32'(idle_cnt), 32'd0);
        step();

        // Bypass at the next-word edge.
        clr(); send(8'hC3); repeat (7) step();
        send(8'h5A); repeat (7) step();
        chk("bypass.stream", cap_m, 32'h0000_C35A);
        chk("bypass.no_hold", 32'(rdy_dropped), 32'd0);
        chk("bypass.gapless", 32'(idle_cnt), 32'd0);
        step();

        // Reset mid-word with a word held.
        clr(); send(8'hFF); send(8'h55); step();
        rst = 1'b1; step();
        rst = 1'b0; step();
        chk("rstmid.bit_valid", 32'(m_bv), 32'd0);
        chk("rstmid.busy",      32'(m_bz), 32'd0);
        chk("rstmid.din_ready", 32'(m_rdy), 32'd1);
        chk("rstmid.no_done",   32'(wd_cnt), 32'd0);
        clr(); send(8'h81); repeat (7) step();
        chk("rstmid.next_word", cap_m, 32'h0000_0081);
        chk("rstmid.next_done", 32'(wd_cnt), 32'd1);
        step();

        // Idle gap of three cycles between words.
        clr(); send(8'hC3); repeat (7) step();
        repeat (3) step();
        chk("gap.idle_cycles", 32'(idle_cnt), 32'd3);
        send(8'h3C); repeat (7) step();
        chk("gap.stream", cap_m, 32'h0000_C33C);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            din_valid = ($urandom_range(0, 9) < 6);
            din       = 8'($urandom);
            step();
        end
        rst = 1'b0; din_valid = 1'b0;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial stage that sits directly upstream of the 1101 sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and drives them out one bit per clock on a registered serial output, which connects to the detector's serial input. A one-word holding buffer lets consecutive words stream with no gap bits.

Parameters:
WIDTH, 8, bits per parallel word (>=2)
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
din  input  WIDTH  parallel word
din_valid  input  1  din holds a word to transfer
din_ready  output  1  block can accept a word this cycle
bit_out  output  1  serial bit, registered; feeds detector serial input
bit_valid  output  1  bit_out carries a real data bit this cycle
word_done  output  1  one-cycle pulse, high with the last bit of each word
busy  output  1  shifter active or holding buffer full

Behaviour:
- Reset (rst high at an edge): state=IDLE, hold buffer empty, bit counter=0. bit_out=0, bit_valid=0, word_done=0. Reset wins over any handshake in the same cycle. din_ready is forced 0 while rst is high.
- din_ready = !rst && !hold_full. It is combinational from registers only and has no path from din_valid.
- A transfer occurs at an edge where din_valid && din_ready.
- Output-side states are IDLE and SHIFT. bit_out, bit_valid and word_done are registered.
- IDLE + transfer at edge N: the word goes straight to the shifter. The first bit is driven from edge N. State becomes SHIFT and the hold buffer stays empty. Latency is 1 cycle from handshake to first bit.
- SHIFT: one bit is driven per edge in order: MSB_FIRST=1 gives WIDTH-1 down to 0; MSB_FIRST=0 gives 0 up to WIDTH-1.
- The counter counts bits emitted. The k-th bit of a word (k=1..WIDTH) is driven from edge N+k-1.
- word_done=1 in exactly the cycle the WIDTH-th bit is on bit_out; it is 0 otherwise.
- Next-word edge (the edge after the last bit is driven):
  - If the hold buffer is full, its word loads into the shifter and the first bit is driven. The buffer empties. No gap.
  - Else, if a transfer occurs at this same edge, the incoming word bypasses to the shifter. No gap.
  - Else, bit_valid is 0, bit_out is 0, and the state returns to IDLE.
- A transfer during SHIFT on any other edge writes the hold buffer. din_ready then drops the next cycle.
- The hold buffer can never be written and read at the same edge while full, because din_ready is 0 in that case.
- bit_out = 0 whenever bit_valid = 0. busy = (state==SHIFT) || hold_full.
- Reset mid-word: the partial word and the held word are discarded. bit_valid goes to 0 from the reset edge. No word_done is issued for the aborted word.
- The block has no backpressure from downstream, because the detector always consumes.

Test Plan:
1. Reset then single word: din=8'hD0, MSB_FIRST=1, handshake at edge N -> bit_out=1,1,0,1,0,0,0,0 on edges N..N+7. bit_valid high for exactly 8 cycles. word_done only at N+7. IDLE, busy=0 from N+8.
2. Back-to-back: 8'hA5 then 8'h3C, din_valid held high -> 16 contiguous valid bits 10100101 00111100 with no gap. din_ready low while the buffer is full. word_done at bits 8 and 16.
3. LSB first: MSB_FIRST=0, din=8'h0B -> bits 1,1,0,1,0,0,0,0. Detector downstream asserts out one cycle after the 4th bit is presented.
4. Bypass: din_valid asserted exactly at the next-word edge with the buffer empty -> first bit of the new word follows the last bit of the previous word with no gap, and the hold buffer is never written.
5. Reset mid-operation: rst high at the 4th bit of 8'hFF with 8'h55 held -> bit_valid=0, busy=0, din_ready=1 the cycle after rst deasserts. No word_done. A subsequent word 8'h81 serializes cleanly.
6. Idle gap: word 8'hC3, 3 idle cycles, word 8'h3C -> 3 cycles of bit_valid=0 and bit_out=0 between the words, with correct bit order in each word.
